// File: rtl/conv_pkg.sv
// Shared types and width helper for the parametrised 1D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    // A sum of M full-precision T x T products needs clog2(M) bits of growth.
    function automatic int out_width(input int t, input int m);
        return 2 * t + $clog2(m);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// P-lane signed multiply, adder tree and accumulator for one tap group per cycle.
module conv_mac
    import conv_pkg::*;
#(
    parameter int T  = 8,
    parameter int P  = 1,
    parameter int OW = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [T-1:0]  x_lane [P],
    input  logic signed [T-1:0]  f_lane [P],
    input  logic                 clear,
    input  logic                 enable,
    output logic signed [OW-1:0] sum
);

    logic signed [2*T-1:0] prod [P];
    logic signed [OW-1:0]  part;
    logic signed [OW-1:0]  acc;

    // sum includes the group being multiplied now, so the final group's total
    // can be registered downstream on the same edge it is produced.
    always_comb begin
        part = '0;
        for (int l = 0; l < P; l++) begin
            prod[l] = x_lane[l] * f_lane[l];
            part    = part + OW'(prod[l]);
        end
        sum = acc + part;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/conv_param.sv
// Parametrised valid-mode 1D convolution over valid/ready streams.
// Optional macro CONV_RELU_EN clamps negative results to zero at registration.
module conv_param
    import conv_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int M  = 4,
    parameter  int T  = 8,
    parameter  int P  = 1,
    localparam int OW = out_width(T, M)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [T-1:0]  s_data_in_x,
    input  logic                 s_valid_x,
    output logic                 s_ready_x,
    input  logic signed [T-1:0]  s_data_in_f,
    input  logic                 s_valid_f,
    output logic                 s_ready_f,
    output logic signed [OW-1:0] m_data_out_y,
    output logic                 m_valid_y,
    input  logic                 m_ready_y
);

    localparam int G  = M / P;
    localparam int XW = $clog2(N + 1);
    localparam int FW = $clog2(M + 1);
    localparam int XI = (N > 1) ? $clog2(N) : 1;
    localparam int FI = (M > 1) ? $clog2(M) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    if (M % P != 0) begin : g_lane_check
        $error("conv_param: M must be a multiple of P");
    end
    if (N < M) begin : g_len_check
        $error("conv_param: N must be at least M");
    end

    state_t state, state_nx;

    logic [XW-1:0] x_cnt;
    logic [FW-1:0] f_cnt;
    logic [XW-1:0] out_idx;
    logic [GW-1:0] tap_grp;

    logic signed [T-1:0] x_mem [N];
    logic signed [T-1:0] f_mem [M];
    logic signed [T-1:0] x_lane [P];
    logic signed [T-1:0] f_lane [P];

    logic x_take, f_take, loaded, last_grp, y_take, last_out;
    logic mac_clr, mac_en;
    logic signed [OW-1:0] mac_sum, result;

    // Readies are gated by the reset pin so nothing is offered while it is held low.
    always_comb begin
        s_ready_x = reset && (state == LOAD) && (x_cnt < XW'(N));
        s_ready_f = reset && (state == LOAD) && (f_cnt < FW'(M));
        x_take    = s_valid_x && s_ready_x;
        f_take    = s_valid_f && s_ready_f;
        loaded    = ((x_cnt == XW'(N)) || (x_take && (x_cnt == XW'(N - 1)))) &&
                    ((f_cnt == FW'(M)) || (f_take && (f_cnt == FW'(M - 1))));
        last_grp  = (tap_grp == GW'(G - 1));
        y_take    = (state == OUTPUT) && m_ready_y;
        last_out  = (out_idx == XW'(N - M));
        mac_en    = (state == COMPUTE);
        mac_clr   = y_take;
        state_nx  = state;
        case (state)
            LOAD:    if (loaded)   state_nx = COMPUTE;
            COMPUTE: if (last_grp) state_nx = OUTPUT;
            OUTPUT:  if (y_take)   state_nx = last_out ? LOAD : COMPUTE;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        int xi, fi;
        for (int l = 0; l < P; l++) begin
            x_lane[l] = '0;
            f_lane[l] = '0;
            fi = int'(tap_grp) * P + l;
            xi = int'(out_idx) + fi;
            for (int k = 0; k < N; k++) if (k == xi) x_lane[l] = x_mem[k];
            for (int k = 0; k < M; k++) if (k == fi) f_lane[l] = f_mem[k];
        end
    end

    always_comb begin
`ifdef CONV_RELU_EN
        result = (mac_sum < 0) ? '0 : mac_sum;
`else
        result = mac_sum;
`endif
    end

    conv_mac #(.T(T), .P(P), .OW(OW)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .x_lane (x_lane),
        .f_lane (f_lane),
        .clear  (mac_clr),
        .enable (mac_en),
        .sum    (mac_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    // Sample storage needs no reset: the cleared counters make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (x_take) x_mem[x_cnt[XI-1:0]] <= s_data_in_x;
        if (f_take) f_mem[f_cnt[FI-1:0]] <= s_data_in_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt        <= '0;
            f_cnt        <= '0;
            out_idx      <= '0;
            tap_grp      <= '0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
        end else begin
            if (x_take) x_cnt <= x_cnt + 1'b1;
            if (f_take) f_cnt <= f_cnt + 1'b1;
            case (state)
                COMPUTE: begin
                    if (last_grp) begin
                        tap_grp      <= '0;
                        m_data_out_y <= result;
                        m_valid_y    <= 1'b1;
                    end else begin
                        tap_grp <= tap_grp + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (last_out) begin
                            out_idx <= '0;
                            x_cnt   <= '0;
                            f_cnt   <= '0;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
